if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use a single clock and reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 stall  input  1  ID/EX hazard hold; freezes PC and IF/ID register.
REQ-005 redirect_valid  input  1  branch/jump/jr/jalr taken, resolved downstream.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-007 imem_ready  input  1  imem_rdata valid for current imem_addr this cycle.
REQ-008 imem_rdata  input  32  instruction word from instruction memory.
REQ-009 imem_req  output  1  fetch request for imem_addr.
REQ-010 imem_addr  output  32  word-aligned fetch address; equals PC_out.
REQ-011 PC_out  output  32  current fetch PC.
REQ-012 id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 id_inst  output  32  IF/ID instruction; 32'h0 (nop) when not valid.
REQ-014 id_pc4  output  32  PC+4 of the IF/ID instruction, for jal/jalr link and branch target.

Function
REQ-015 The block SHALL implement states BOOT, FETCH, HOLD in a registered state machine.
REQ-016 BOOT: entered on reset; imem_req=0; unconditional transition to FETCH next cycle.
REQ-017 FETCH: imem_req=1; advance condition = imem_ready & ~stall & ~redirect_valid.
REQ-018 On the advance condition, at the next edge: id_inst<=imem_rdata, id_pc4<=PC_out+4, id_valid<=1, PC_out<=PC_out+4; state remains FETCH.
REQ-019 FETCH with ~imem_ready & ~redirect_valid: PC_out held; id_valid<=0, id_inst<=0 unless stall=1, in which case IF/ID is held unchanged.
REQ-020 FETCH with imem_ready & stall & ~redirect_valid: imem_rdata captured into a one-entry skid buffer; IF/ID and PC_out held; next state HOLD.
REQ-021 HOLD: imem_req=0; PC_out and IF/ID held while stall=1.
REQ-022 HOLD with stall=0 & ~redirect_valid: IF/ID loaded from skid buffer (id_pc4=PC_out+4, id_valid=1), PC_out<=PC_out+4, next state FETCH.
REQ-023 Redirect priority: redirect_valid=1 in any non-BOOT state overrides stall and imem_ready; next edge PC_out<={redirect_pc[31:2],2'b00}, id_valid<=0, id_inst<=0, skid buffer discarded, next state FETCH.
REQ-024 Response arriving in the same cycle as redirect_valid SHALL be dropped, never written to IF/ID.
REQ-025 redirect_valid during BOOT SHALL be ignored.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 32'h00000000, no flag.
REQ-027 Fetch latency: instruction returned with imem_ready in cycle N is visible on id_inst in cycle N+1.
REQ-028 Throughput: one instruction per cycle when imem_ready=1, stall=0, no redirect.
REQ-029 imem_addr SHALL be combinationally equal to PC_out; imem_addr[1:0] always 2'b00.

Reset
REQ-030 While rst=1: state=BOOT, PC_out=32'h00000000, imem_req=0, id_valid=0, id_inst=32'h0, id_pc4=32'h0, skid buffer empty.
REQ-031 Reset asserted mid-fetch or in HOLD SHALL clear all state immediately, without waiting for a clock edge; buffered data discarded.
REQ-032 After rst deasserts: one BOOT cycle, then first request to address 0.

Verification
REQ-033 Reset release, imem_ready=1, rdata=PC-indexed ROM (0x20080000 at 0, 0x3409000F at 4) -> cycle 2 id_inst=0x20080000, id_pc4=4; cycle 3 id_inst=0x3409000F, id_pc4=8, PC_out=8.
REQ-034 stall=1 for 3 cycles at PC=8 with imem_ready=1 -> state HOLD, PC_out=8, IF/ID frozen; on release id_inst=word@8, id_pc4=12, PC_out=12, no instruction lost or duplicated.
REQ-035 redirect_valid=1, redirect_pc=0x00000043 while stall=1 -> next cycle PC_out=0x00000040, id_valid=0, id_inst=0, state FETCH.
REQ-036 imem_ready=0 for 2 cycles at PC=0x10 -> imem_req=1, PC_out=0x10 held, id_valid=0; ready returns -> id_inst=word@0x10, id_pc4=0x14.
REQ-037 redirect to 0xFFFFFFFC, ready=1 -> id_pc4=0x00000000, PC_out wraps to 0x00000000.
REQ-038 rst pulsed asynchronously between edges while in HOLD -> all outputs reach reset values before next clk edge; fetch restarts at 0.

Source files
------------

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage, instruction memory, the hazard unit
// and the decode stage. The fetch stage is the master.
interface if_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC_out;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, PC_out, id_valid, id_inst, id_pc4
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, PC_out, id_valid, id_inst, id_pc4
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// one-entry skid buffer that catches a fetch returning during a stall.
module if_stage (
    input  logic          clk,
    input  logic          rst,
    if_stage_if.master    bus
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        imem_req_q;
    logic        id_valid_q;
    logic [31:0] id_inst_q;
    logic [31:0] id_pc4_q;
    logic [31:0] skid_data;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;

    assign pc_plus4         = pc + 32'd4;
    assign redirect_aligned = bus.redirect_pc & ~32'h0000_0003;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the skid buffer is a plain register and is reset too,
    // keeping it deterministic after an asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= 32'h0;
            imem_req_q <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= 32'h0;
            id_pc4_q   <= 32'h0;
            skid_data  <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= FETCH;
                    imem_req_q <= 1'b1;
                end

                FETCH: begin
                    if (bus.redirect_valid) begin
                        pc         <= redirect_aligned;
                        id_valid_q <= 1'b0;
                        id_inst_q  <= 32'h0;
                    end else if (bus.imem_ready && !bus.stall) begin
                        pc         <= pc_plus4;
                        id_valid_q <= 1'b1;
                        id_inst_q  <= bus.imem_rdata;
                        id_pc4_q   <= pc_plus4;
                    end else if (bus.imem_ready) begin
                        // Decode is frozen: park the returned word until release.
                        skid_data  <= bus.imem_rdata;
                        state      <= HOLD;
                        imem_req_q <= 1'b0;
                    end else if (!bus.stall) begin
                        id_valid_q <= 1'b0;
                        id_inst_q  <= 32'h0;
                    end
                end

                HOLD: begin
                    if (bus.redirect_valid) begin
                        pc         <= redirect_aligned;
                        id_valid_q <= 1'b0;
                        id_inst_q  <= 32'h0;
                        state      <= FETCH;
                        imem_req_q <= 1'b1;
                    end else if (!bus.stall) begin
                        pc         <= pc_plus4;
                        id_valid_q <= 1'b1;
                        id_inst_q  <= skid_data;
                        id_pc4_q   <= pc_plus4;
                        state      <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end

                default: begin
                    state      <= BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc;
    assign bus.PC_out    = pc;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_inst   = id_inst_q;
    assign bus.id_pc4    = id_pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a scoreboard queue holds every instruction
// decode should accept, and a negedge monitor pops it when decode takes one.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    if_stage_if bus ();

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: two fixed words, every other address a tagged pattern.
    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h2008_0000;
            32'h0000_0004: return 32'h3409_000F;
            default:       return 32'hC0DE_0000 ^ addr;
        endcase
    endfunction

    assign bus.imem_rdata = rom(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc4);
        exp_q.push_back('{inst: inst, pc4: pc4});
    endtask

    task automatic check_pc(input string name, input logic [31:0] pc);
        check({name, "_pc"}, bus.PC_out, pc);
        check({name, "_addr"}, bus.imem_addr, pc);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_pc"},    bus.PC_out,   32'h0);
        check({name, "_req"},   {31'h0, bus.imem_req}, 32'h0);
        check({name, "_valid"}, {31'h0, bus.id_valid}, 32'h0);
        check({name, "_inst"},  bus.id_inst,  32'h0);
        check({name, "_pc4"},   bus.id_pc4,   32'h0);
    endtask

    // Decode accepts the IF/ID contents when valid, not stalled and not flushed.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.id_valid === 1'b1 &&
            bus.stall === 1'b0 && bus.redirect_valid === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got inst %h pc4 %h, expected none", bus.id_inst, bus.id_pc4);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_inst", bus.id_inst, e.inst);
                check("sb_pc4",  bus.id_pc4,  e.pc4);
            end
        end
    end

    initial begin
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_ready     = 1'b1;

        repeat (2) step();
        check_reset_outputs("reset");

        rst = 1'b0;
        check("boot_req", {31'h0, bus.imem_req}, 32'h0);
        push(32'h2008_0000, 32'h4);
        push(32'h3409_000F, 32'h8);

        step();                                   // BOOT -> FETCH
        check("first_req", {31'h0, bus.imem_req}, 32'h1);
        check_pc("first", 32'h0);
        step();
        check("c2_inst", bus.id_inst, 32'h2008_0000);
        check("c2_pc4",  bus.id_pc4,  32'h4);
        step();
        check("c3_inst", bus.id_inst, 32'h3409_000F);
        check("c3_pc4",  bus.id_pc4,  32'h8);
        check_pc("c3", 32'h8);

        // Three stalled cycles at PC 8 with memory ready.
        bus.stall = 1'b1;
        push(32'hC0DE_0008, 32'hC);
        push(32'hC0DE_000C, 32'h10);
        step();
        check("hold_req", {31'h0, bus.imem_req}, 32'h0);
        step();
        step();
        check_pc("hold", 32'h8);
        check("hold_inst", bus.id_inst, 32'h3409_000F);
        check("hold_pc4",  bus.id_pc4,  32'h8);
        bus.stall = 1'b0;
        step();
        check("rel_inst", bus.id_inst, 32'hC0DE_0008);
        check("rel_pc4",  bus.id_pc4,  32'hC);
        check_pc("rel", 32'hC);
        check("rel_req", {31'h0, bus.imem_req}, 32'h1);
        step();                                   // word@0xC, PC now 0x10

        // Memory not ready for two cycles at 0x10.
        bus.imem_ready = 1'b0;
        step();
        check("nr_valid", {31'h0, bus.id_valid}, 32'h0);
        check("nr_inst",  bus.id_inst, 32'h0);
        step();
        check("nr_req", {31'h0, bus.imem_req}, 32'h1);
        check_pc("nr", 32'h10);
        bus.imem_ready = 1'b1;
        step();
        check("nr_ret_inst", bus.id_inst, 32'hC0DE_0010);
        check("nr_ret_pc4",  bus.id_pc4,  32'h14);

        // Stall into HOLD, then redirect while still stalled; 0x10 is flushed.
        bus.stall = 1'b1;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0043;
        step();
        check_pc("redir", 32'h40);
        check("redir_valid", {31'h0, bus.id_valid}, 32'h0);
        check("redir_inst",  bus.id_inst, 32'h0);
        check("redir_req",   {31'h0, bus.imem_req}, 32'h1);
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        push(32'hC0DE_0040, 32'h44);
        step();
        step();                                   // word@0x44 loaded, flushed next

        // Redirect to the top word; the 0x48 response in that cycle is dropped.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        check_pc("top", 32'hFFFF_FFFC);
        check("drop_valid", {31'h0, bus.id_valid}, 32'h0);
        bus.redirect_valid = 1'b0;
        push(32'h3F21_FFFC, 32'h0);
        step();
        check("wrap_inst", bus.id_inst, 32'h3F21_FFFC);
        check("wrap_pc4",  bus.id_pc4,  32'h0);
        check_pc("wrap", 32'h0);
        step();                                   // word@0 loaded, never accepted

        // Enter HOLD, then pulse reset between clock edges.
        bus.stall = 1'b1;
        step();
        check("pre_rst_req", {31'h0, bus.imem_req}, 32'h0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        rst       = 1'b0;
        bus.stall = 1'b0;
        push(32'h2008_0000, 32'h4);
        push(32'h3409_000F, 32'h8);
        step();                                   // BOOT -> FETCH
        check_pc("restart", 32'h0);
        step();
        check("rs_inst", bus.id_inst, 32'h2008_0000);
        step();
        check("rs_inst2", bus.id_inst, 32'h3409_000F);
        bus.imem_ready = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("sb_drain", exp_q.size(), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
